clm_reducer: RTL and testbench
==============================

CLM_REDUCER -- requirements
Module: clm_reducer

Interface
REQ-001 Parameter d, default d (package value), number of redundant bits; SHALL be >= 1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 drdy_i  input  1  input-valid strobe from multiplier drdy_o.
REQ-005 in  input  state_t (8+d)  redundant product from multiplier out; index i = coefficient of x^(7+d-i).
REQ-006 P  input  8  low 8 coefficients of the field polynomial (x^8 implicit); P[0] = x^7 … P[7] = x^0.
REQ-007 out  output  8  canonical field element; out[0] = x^7.
REQ-008 drdy_o  output  1  one-cycle result-valid pulse.
REQ-009 busy  output  1  high while a reduction is in progress.

Function
REQ-010 Purpose: serially reduce an (8+d)-bit redundant value modulo x^8+P to its unique 8-bit canonical value; one redundant bit cleared per cycle.
REQ-011 States: IDLE, REDUCE, DONE; IDLE after reset.
REQ-012 drdy_i sampled high in any state: load accumulator <= in, latch P, clear step counter k, go REDUCE.
REQ-013 REDUCE, step k (0..d-1): if acc[k]=1, acc ^= (x^8+P)·x^(d-1-k), i.e. clear acc[k] and XOR P[0:7] into acc[k+1:k+8]; else acc unchanged; k <= k+1.
REQ-014 After step k=d-1: out <= acc[d:7+d], go DONE; acc[0:d-1] SHALL be zero at this point.
REQ-015 DONE: drdy_o = 1 for exactly that cycle; next state IDLE unless drdy_i is high (REQ-012).
REQ-016 Latency: drdy_i high in cycle T -> drdy_o high in cycle T+d+1, never earlier or later.
REQ-017 drdy_i during REDUCE: current operation aborted, no drdy_o for it, restart with new in/P.
REQ-018 drdy_i during DONE: drdy_o still pulses for the finished result; new operation starts in the same edge.
REQ-019 out registered; holds last result until next DONE; changes only on entry to DONE.
REQ-020 busy = 1 exactly in REDUCE.
REQ-021 P changing while busy SHALL NOT affect the result (latched copy used).
REQ-022 Counter width $clog2(d+1); no out-of-range index into acc at any k.

Reset
REQ-023 rst high at a clock edge: state IDLE, acc = 0, k = 0, latched P = 0, out = 0, drdy_o = 0, busy = 0.
REQ-024 rst dominates drdy_i in the same cycle; rst mid-operation discards it, no drdy_o afterwards.
REQ-025 Synchronous reset only; no asynchronous reset terms in any always block.

Structure
REQ-026 state_t, red_poly_t, d and a reducer state enum SHALL live in the shared types package; no local redefinition.
REQ-027 One combinational sub-module clm_reduce_step (inputs acc, k, P; output next acc) implementing REQ-013; instantiated once.
REQ-028 Total RTL within 120-400 lines including the sub-module.

Verification (d=2, P=0x1B, AES)
REQ-029 in=0x37E, drdy_i at T -> drdy_o at T+3, out=0x53; busy high T+1..T+2.
REQ-030 in=0x0A5 (redundant bits zero) -> out=0xA5 at T+3, acc unchanged across steps.
REQ-031 in=0x3FF -> out=0xD2 at T+3.
REQ-032 in=0x37E at T, in=0x0A5 at T+1 -> single drdy_o at T+4, out=0xA5; none at T+3.
REQ-033 in=0x37E at T, rst at T+1 -> out=0, drdy_o never pulses; next op in=0x3FF gives 0xD2 normally.
REQ-034 Random: 10^4 vectors v·(x^8+P)+c, random v, c -> out=c; back-to-back drdy_i in each DONE cycle.

Source files
------------

// File: rtl/clm_reducer_pkg.sv
// Shared types for the serial carry-less reducer: redundant product width,
// field polynomial and the reducer FSM states.
package clm_reducer_pkg;

  localparam int d = 2;

  // Index 0 holds the highest-degree coefficient in both types.
  typedef logic [0:d+7] state_t;
  typedef logic [0:7]   red_poly_t;

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    DONE
  } red_state_e;

endpackage

// File: rtl/clm_reduce_step.sv
// One reduction step: clears redundant bit k of the accumulator by folding
// (x^8 + P) * x^(d-1-k) into it when that bit is set.
module clm_reduce_step
  import clm_reducer_pkg::*;
#(
  parameter int d  = clm_reducer_pkg::d,
  parameter int KW = $clog2(d + 1)
) (
  input  state_t          acc,
  input  logic [KW-1:0]   k,
  input  red_poly_t       P,
  output state_t          next_acc
);

  // Loop over legal step positions only, so k never indexes past acc.
  always_comb begin
    next_acc = acc;
    for (int j = 0; j < d; j++) begin
      if ((int'(k) == j) && acc[j]) begin
        next_acc[j] = 1'b0;
        for (int b = 0; b < 8; b++) begin
          next_acc[j+1+b] = acc[j+1+b] ^ P[b];
        end
      end
    end
  end

endmodule

// File: rtl/clm_reducer.sv
// Serial reducer: takes an (8+d)-bit redundant product and clears one
// redundant bit per cycle, presenting the canonical 8-bit value after d steps.
module clm_reducer
  import clm_reducer_pkg::*;
#(
  parameter int d = clm_reducer_pkg::d
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       drdy_i,
  input  state_t     in,
  input  red_poly_t  P,
  output logic [0:7] out,
  output logic       drdy_o,
  output logic       busy
);

  localparam int KW = $clog2(d + 1);

  red_state_e    state, state_nxt;
  state_t        acc, acc_nxt, step_acc;
  red_poly_t     poly_q, poly_nxt;
  logic [KW-1:0] k, k_nxt;
  logic [0:7]    out_nxt;

  clm_reduce_step #(.d(d), .KW(KW)) u_step (
    .acc      (acc),
    .k        (k),
    .P        (poly_q),
    .next_acc (step_acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      k      <= '0;
      poly_q <= '0;
      out    <= '0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      k      <= k_nxt;
      poly_q <= poly_nxt;
      out    <= out_nxt;
    end
  end

  // A new operand always wins: it restarts the reduction from any state,
  // silently dropping an unfinished one.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    k_nxt     = k;
    poly_nxt  = poly_q;
    out_nxt   = out;
    if (drdy_i) begin
      state_nxt = REDUCE;
      acc_nxt   = in;
      poly_nxt  = P;
      k_nxt     = '0;
    end else begin
      case (state)
        REDUCE: begin
          acc_nxt = step_acc;
          k_nxt   = k + KW'(1);
          if (k == KW'(d - 1)) begin
            out_nxt   = step_acc[d +: 8];
            state_nxt = DONE;
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign drdy_o = (state == DONE);
  assign busy   = (state == REDUCE);

endmodule

// File: tb/tb_clm_reducer.sv
// Self-checking bench for clm_reducer: directed AES cases, abort/reset cases
// and back-to-back random operands, all checked against a polynomial model.
module tb_clm_reducer;
  import clm_reducer_pkg::*;

  localparam int D    = d;
  localparam int MAXC = 40000;

  logic       clk = 1'b0;
  logic       rst;
  logic       drdy_i;
  state_t     in;
  red_poly_t  P;
  logic [0:7] out;
  logic       drdy_o;
  logic       busy;

  clm_reducer #(.d(D)) dut (
    .clk    (clk),
    .rst    (rst),
    .drdy_i (drdy_i),
    .in     (in),
    .P      (P),
    .out    (out),
    .drdy_o (drdy_o),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Per-cycle input history, plus the literal result an op is built to give.
  bit drv_h [MAXC];
  bit rst_h [MAXC];
  int in_h  [MAXC];
  int p_h   [MAXC];
  int lit_h [MAXC];

  int cyc = 0;
  int dcyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int nchk = 0;
  bit seen_rst = 1'b0;
  logic [7:0] exp_out = 8'h00;

  // Remainder of a modulo x^8 + p by GF(2) long division.
  function automatic logic [7:0] poly_mod(input int a, input int p);
    int r;
    r = a;
    for (int deg = 7 + D; deg >= 8; deg--) begin
      if (r[deg]) r = r ^ ((32'h100 | p) << (deg - 8));
    end
    return r[7:0];
  endfunction

  function automatic int clmul(input int v, input int m);
    int r;
    r = 0;
    for (int i = 0; i < D; i++) begin
      if (v[i]) r = r ^ (m << i);
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input int got, input int want);
    nchk++;
    if (got != want) begin
      miscompares++;
      $display("[TB] FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  task automatic applyStimulus(input bit dr, input int val, input int p,
                               input bit r, input int lit);
    @(posedge clk);
    #1;
    drdy_i = dr;
    in     = state_t'(val);
    P      = red_poly_t'(p);
    rst    = r;
    lit_h[dcyc] = dr ? lit : -1;
    if (dr) vectors++;
    dcyc++;
  endtask

  // Compare process: outputs of this cycle follow from the last event
  // (operand or reset) within the previous d+1 cycles.
  always @(negedge clk) begin
    bit found, exp_busy, exp_drdy;
    int e, lit;
    if (cyc == 0) begin
      checkOutput("pin_37e", int'(poly_mod(32'h37E, 32'h1B)), 32'h53);
      checkOutput("pin_3ff", int'(poly_mod(32'h3FF, 32'h1B)), 32'hD2);
      checkOutput("pin_0a5", int'(poly_mod(32'h0A5, 32'h1B)), 32'hA5);
    end
    if (cyc > 0 && rst_h[cyc-1]) begin
      seen_rst = 1'b1;
      exp_out  = 8'h00;
    end
    found = 1'b0; exp_busy = 1'b0; exp_drdy = 1'b0; lit = -1; e = 0;
    for (int back = 1; back <= D + 1; back++) begin
      if (!found && back <= cyc) begin
        e = cyc - back;
        if (rst_h[e]) found = 1'b1;
        else if (drv_h[e]) begin
          found = 1'b1;
          if (back <= D) exp_busy = 1'b1;
          else begin
            exp_drdy = 1'b1;
            exp_out  = poly_mod(in_h[e], p_h[e]);
            lit      = lit_h[e];
          end
        end
      end
    end
    if (seen_rst) begin
      checkOutput("drdy_o", int'(drdy_o), int'(exp_drdy));
      checkOutput("busy", int'(busy), int'(exp_busy));
      checkOutput("out", int'(out), int'(exp_out));
      if (exp_drdy && lit >= 0) checkOutput("out_literal", int'(out), lit);
    end
    if (cyc < MAXC) begin
      drv_h[cyc] = drdy_i;
      rst_h[cyc] = rst;
      in_h[cyc]  = int'(in);
      p_h[cyc]   = int'(P);
    end else begin
      checkOutput("history_overflow", cyc, MAXC - 1);
    end
    cyc++;
  end

  initial begin
    int p, v, c;
    rst = 1'b1; drdy_i = 1'b0; in = '0; P = '0;
    applyStimulus(0, 0, 0, 1, -1);
    applyStimulus(1, 32'h37E, 32'h1B, 1, -1);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 0, -1);

    applyStimulus(1, 32'h37E, 32'h1B, 0, 32'h53);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 32'h1B, 0, -1);
    applyStimulus(1, 32'h0A5, 32'h1B, 0, 32'hA5);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 32'h1B, 0, -1);
    applyStimulus(1, 32'h3FF, 32'h1B, 0, 32'hD2);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 32'h1B, 0, -1);

    applyStimulus(1, 32'h37E, 32'h1B, 0, 32'h53);
    applyStimulus(1, 32'h0A5, 32'h1B, 0, 32'hA5);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 32'h1B, 0, -1);

    applyStimulus(1, 32'h37E, 32'h1B, 0, 32'h53);
    applyStimulus(0, 0, 32'h1B, 1, -1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 32'h1B, 0, -1);
    applyStimulus(1, 32'h3FF, 32'h1B, 0, 32'hD2);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 32'h1B, 0, -1);

    applyStimulus(1, 32'h37E, 32'h1B, 0, 32'h53);
    for (int i = 0; i < 3; i++) applyStimulus(0, 32'h3FF, 32'hFF, 0, -1);

    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 2) == 0), int'($urandom_range(0, (1 << (D + 8)) - 1)),
                    int'($urandom_range(0, 255)), ($urandom_range(0, 39) == 0), -1);
    end
    applyStimulus(0, 0, 0, 1, -1);

    for (int n = 0; n < 10000; n++) begin
      p = int'($urandom_range(0, 255));
      v = int'($urandom_range(0, (1 << D) - 1));
      c = int'($urandom_range(0, 255));
      applyStimulus(1, clmul(v, 32'h100 | p) ^ c, p, 0, c);
      for (int i = 0; i < D; i++) begin
        applyStimulus(0, int'($urandom_range(0, (1 << (D + 8)) - 1)),
                      int'($urandom_range(0, 255)), 0, -1);
      end
    end
    for (int i = 0; i < D + 3; i++) applyStimulus(0, 0, 0, 0, -1);
    @(negedge clk);
    #1;
    $display("[TB] %0d comparisons made", nchk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
